// File: rtl/data_path_muxs_pkg.sv
// Shared datapath mux selects and fetch-sequencer types.
// pcsrc_t drives the next-PC mux; redir_sel_t is ordered by priority.
package data_path_muxs_pkg;

  typedef enum logic [1:0] {
    SEL_LOAD_NXT_INSTR = 2'd0,
    SEL_LOAD_BR_ADDR   = 2'd1,
    SEL_LOAD_JR_ADDR   = 2'd2,
    SEL_LOAD_JMP_ADDR  = 2'd3
  } pcsrc_t;

  // Encoded so a larger value means a higher-priority redirect.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    JMP  = 2'd1,
    JR   = 2'd2,
    BR   = 2'd3
  } redir_sel_t;

  typedef enum logic [2:0] {
    RST_GAP    = 3'd0,
    FETCH      = 3'd1,
    REDIR_WAIT = 3'd2,
    DRAIN      = 3'd3,
    HALTED     = 3'd4
  } fseq_state_t;

  function automatic redir_sel_t redir_max(
    input redir_sel_t a,
    input redir_sel_t b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic pcsrc_t to_pcsrc(input redir_sel_t r);
    pcsrc_t s;
    unique case (r)
      BR:      s = SEL_LOAD_BR_ADDR;
      JR:      s = SEL_LOAD_JR_ADDR;
      JMP:     s = SEL_LOAD_JMP_ADDR;
      default: s = SEL_LOAD_NXT_INSTR;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer <-> datapath bundle.
// master: sequencer (drives iREN/pc_adv/PCSrc/flushes/halted/stall_cnt).
interface fetch_sequencer_if
  import data_path_muxs_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic             ihit;
  logic             hz_stall;
  logic             jump_id;
  logic             jr_ex;
  logic             br_taken_ex;
  logic             halt_id;
  logic             iREN;
  logic             pc_adv;
  pcsrc_t           PCSrc;
  logic             flush_ifid;
  logic             flush_idex;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  ihit, hz_stall, jump_id,
    input  jr_ex, br_taken_ex, halt_id,
    output iREN, pc_adv, PCSrc,
    output flush_ifid, flush_idex,
    output halted, stall_cnt
  );

  modport slave (
    output ihit, hz_stall, jump_id,
    output jr_ex, br_taken_ex, halt_id,
    input  iREN, pc_adv, PCSrc,
    input  flush_ifid, flush_idex,
    input  halted, stall_cnt
  );

endinterface

// File: rtl/fetch_sequencer.sv
// PC-advance / next-PC-select controller with held redirects and halt.
// Ports: CLK, nRST (sync, active-high), bus (fetch_sequencer_if.master).
module fetch_sequencer
  import data_path_muxs_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic               CLK,
  input logic               nRST,
  fetch_sequencer_if.master bus
);

  fseq_state_t      state_q, state_d;
  redir_sel_t       pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  redir_sel_t ex_sel, req;
  pcsrc_t     src;
  logic       iren, adv;
  logic       fl_ifid, fl_idex;

  always_comb begin
    ex_sel = NONE;
    if (bus.br_taken_ex)
      ex_sel = BR;
    else if (bus.jr_ex)
      ex_sel = JR;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    req     = NONE;
    iren    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      RST_GAP: state_d = FETCH;
      FETCH: begin
        iren = 1'b1;
        // A jump under hz_stall is still frozen in ID; it comes back.
        if (ex_sel != NONE)
          req = ex_sel;
        else if (bus.jump_id && !bus.hz_stall)
          req = JMP;
        if (req != NONE) begin
          if (bus.ihit) begin
            adv = 1'b1;
          end else begin
            pend_d  = req;
            state_d = REDIR_WAIT;
          end
        end else begin
          adv = bus.ihit & ~bus.hz_stall;
          if (bus.halt_id)
            state_d = DRAIN;
        end
      end
      REDIR_WAIT: begin
        iren   = 1'b1;
        req    = redir_max(pend_q, ex_sel);
        pend_d = req;
        if (bus.ihit) begin
          adv     = 1'b1;
          pend_d  = NONE;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // No fetch is outstanding, so a squashing redirect loads now.
        req = ex_sel;
        if (ex_sel != NONE) begin
          adv     = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = HALTED;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = RST_GAP;
    endcase
    src     = to_pcsrc(req);
    fl_ifid = adv & (req != NONE);
    fl_idex = adv & ((req == BR) | (req == JR));
    cnt_d   = cnt_q;
    if (iren && !adv && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= RST_GAP;
      pend_q  <= NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces quiet outputs in the same cycle it is asserted.
  assign bus.iREN       = iren & ~nRST;
  assign bus.pc_adv     = adv & ~nRST;
  assign bus.PCSrc      = nRST ? SEL_LOAD_NXT_INSTR : src;
  assign bus.flush_ifid = fl_ifid & ~nRST;
  assign bus.flush_idex = fl_idex & ~nRST;
  assign bus.halted     = ~nRST & (state_q == HALTED);
  assign bus.stall_cnt  = cnt_q;

endmodule
